// File: rtl/title_pkg.sv
// Shared types and helpers for the title marquee: glyph codes, FSM states, font-ROM offset mapping.
package title_pkg;

  localparam logic [5:0] GLYPH_SPACE = 6'd32;
  localparam int         GLYPH_SHIFT = 3;
  localparam logic [8:0] ROM_SPACE   = 9'h100;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STATIC,
    HOLD_START,
    SCROLL,
    HOLD_END
  } title_state_t;

  function automatic logic [8:0] glyph_to_rom(input logic [5:0] glyph);
    return {3'b000, glyph} << GLYPH_SHIFT;
  endfunction

endpackage

// File: rtl/title_char_buf.sv
// Glyph store with one write port and VISIBLE read taps at offset+i, masked to space beyond len.
// A write in the same cycle is bypassed to the taps so the final glyph shows on the load_last edge.
module title_char_buf
  import title_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int VISIBLE = 12,
  localparam int AW     = $clog2(MAX_LEN),
  localparam int LW     = AW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [5:0]              wr_glyph_i,
  input  logic [LW-1:0]           rd_offset_i,
  input  logic [LW-1:0]           rd_len_i,
  output logic [VISIBLE-1:0][8:0] tap_o
);

  logic [5:0]                    mem_q [MAX_LEN];
  logic [VISIBLE-1:0][LW-1:0]    tap_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= GLYPH_SPACE;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_glyph_i;
    end
  end

  always_comb begin
    for (int i = 0; i < VISIBLE; i++) begin
      tap_idx[i] = rd_offset_i + LW'(i);
      if (tap_idx[i] >= rd_len_i) begin
        tap_o[i] = ROM_SPACE;
      end else if (wr_en_i && (tap_idx[i] == {1'b0, wr_addr_i})) begin
        tap_o[i] = glyph_to_rom(wr_glyph_i);
      end else begin
        tap_o[i] = glyph_to_rom(mem_q[tap_idx[i][AW-1:0]]);
      end
    end
  end

endmodule

// File: rtl/title_scroller.sv
// Title line source: loads glyphs over valid/ready, shows a 12-glyph window, marquee-scrolls long titles.
// Window registers update only on load_start, the load_last transfer, or a frame_tick that moves offset.
module title_scroller
  import title_pkg::*;
#(
  parameter int MAX_LEN     = 32,
  parameter int VISIBLE     = 12,
  parameter int HOLD_FRAMES = 60,
  parameter int STEP_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       load_start,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [5:0] load_glyph,
  input  logic       load_last,
  output logic [8:0] char1,
  output logic [8:0] char2,
  output logic [8:0] char3,
  output logic [8:0] char4,
  output logic [8:0] char5,
  output logic [8:0] char6,
  output logic [8:0] char7,
  output logic [8:0] char8,
  output logic [8:0] char9,
  output logic [8:0] char10,
  output logic [8:0] char11,
  output logic [8:0] char12,
  output logic       scrolling
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int LW   = AW + 1;
  localparam int FMAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
  localparam int CW   = (FMAX > 1) ? $clog2(FMAX) : 1;

  title_state_t              state_q, state_d;
  logic [LW-1:0]             len_q, len_d;
  logic [LW-1:0]             offset_q, offset_d;
  logic [CW-1:0]             fcnt_q, fcnt_d;
  logic [VISIBLE-1:0][8:0]   win_q, win_d;
  logic                      scrolling_q, scrolling_d;
  logic [VISIBLE-1:0][8:0]   taps;
  logic                      xfer, wr_en, win_upd;

  assign load_ready = (state_q == LOAD);
  assign xfer       = load_valid && load_ready;
  // Glyphs past MAX_LEN are accepted but never written.
  assign wr_en      = xfer && !load_start && (len_q < LW'(MAX_LEN));

  title_char_buf #(
    .MAX_LEN (MAX_LEN),
    .VISIBLE (VISIBLE)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_addr_i   (len_q[AW-1:0]),
    .wr_glyph_i  (load_glyph),
    .rd_offset_i (offset_d),
    .rd_len_i    (len_d),
    .tap_o       (taps)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    offset_d = offset_q;
    fcnt_d   = fcnt_q;
    win_upd  = 1'b0;
    if (load_start) begin
      state_d  = LOAD;
      len_d    = '0;
      offset_d = '0;
      fcnt_d   = '0;
      win_upd  = 1'b1;
    end else begin
      case (state_q)
        LOAD: if (xfer) begin
          if (len_q < LW'(MAX_LEN)) len_d = len_q + 1'b1;
          if (load_last) begin
            win_upd = 1'b1;
            state_d = (len_d <= LW'(VISIBLE)) ? STATIC : HOLD_START;
          end
        end
        HOLD_START: if (frame_tick) begin
          if (fcnt_q == CW'(HOLD_FRAMES - 1)) begin
            fcnt_d  = '0;
            state_d = SCROLL;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        SCROLL: if (frame_tick) begin
          if (fcnt_q == CW'(STEP_FRAMES - 1)) begin
            fcnt_d   = '0;
            offset_d = offset_q + 1'b1;
            win_upd  = 1'b1;
            if (offset_d == len_q - LW'(VISIBLE)) state_d = HOLD_END;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        HOLD_END: if (frame_tick) begin
          if (fcnt_q == CW'(HOLD_FRAMES - 1)) begin
            fcnt_d   = '0;
            offset_d = '0;
            win_upd  = 1'b1;
            state_d  = HOLD_START;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    win_d = win_q;
    if (win_upd) win_d = (state_d == LOAD) ? {VISIBLE{ROM_SPACE}} : taps;
    scrolling_d = state_d inside {HOLD_START, SCROLL, HOLD_END};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      offset_q    <= '0;
      fcnt_q      <= '0;
      win_q       <= {VISIBLE{ROM_SPACE}};
      scrolling_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      offset_q    <= offset_d;
      fcnt_q      <= fcnt_d;
      win_q       <= win_d;
      scrolling_q <= scrolling_d;
    end
  end

  assign scrolling = scrolling_q;
  assign char1  = win_q[0];
  assign char2  = win_q[1];
  assign char3  = win_q[2];
  assign char4  = win_q[3];
  assign char5  = win_q[4];
  assign char6  = win_q[5];
  assign char7  = win_q[6];
  assign char8  = win_q[7];
  assign char9  = win_q[8];
  assign char10 = win_q[9];
  assign char11 = win_q[10];
  assign char12 = win_q[11];

endmodule

// File: tb/tb_title_scroller.sv
// Scoreboard bench for title_scroller with HOLD_FRAMES=2, STEP_FRAMES=1.
module tb_title_scroller;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_tick, load_start, load_valid, load_last;
  logic [5:0]      load_glyph;
  logic            load_ready, scrolling;
  wire [11:0][8:0] chv;

  int              checks = 0;
  int              errors = 0;
  logic [8:0]      exp_q [$];
  logic [5:0]      mbuf [32];
  int              mlen;

  always #5 clk = ~clk;

  title_scroller #(
    .MAX_LEN(32), .VISIBLE(12), .HOLD_FRAMES(2), .STEP_FRAMES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .load_start(load_start),
    .load_valid(load_valid), .load_ready(load_ready), .load_glyph(load_glyph),
    .load_last(load_last),
    .char1(chv[0]), .char2(chv[1]), .char3(chv[2]), .char4(chv[3]),
    .char5(chv[4]), .char6(chv[5]), .char7(chv[6]), .char8(chv[7]),
    .char9(chv[8]), .char10(chv[9]), .char11(chv[10]), .char12(chv[11]),
    .scrolling(scrolling)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_spaces();
    for (int i = 0; i < 12; i++) exp_q.push_back(9'h100);
  endtask

  task automatic push_window(input int off);
    for (int i = 0; i < 12; i++)
      exp_q.push_back((off + i < mlen) ? {mbuf[off + i], 3'b000} : 9'h100);
  endtask

  task automatic check_window(input string tag);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s.c%0d", tag, i + 1), chv[i], exp_q.pop_front());
  endtask

  task automatic pulse_start();
    load_start = 1'b1; cyc(); load_start = 1'b0;
    mlen = 0;
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
  endtask

  task automatic send_glyph(input logic [5:0] g, input logic last);
    if (mlen < 32) begin
      mbuf[mlen] = g;
      mlen++;
    end
    load_valid = 1'b1; load_glyph = g; load_last = last;
    cyc();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic send_title(input string s);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_glyph((c == 8'd32) ? 6'd32 : 6'(c - 8'd96), i == s.len() - 1);
    end
  endtask

  // Reset is asserted and checked between clock edges so only the async path can clear outputs.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    push_spaces(); check_window(tag);
    chk({tag, ".scr"}, scrolling, 1'b0);
    chk({tag, ".rdy"}, load_ready, 1'b0);
    #4 rst_n = 1'b1;
    cyc(); cyc();
    chk({tag, ".rdy_after"}, load_ready, 1'b0);
    mlen = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int scroll_off [8] = '{0, 0, 1, 2, 3, 4, 4, 0};
    int short_off  [5] = '{0, 0, 1, 1, 0};
    rst_n = 1'b0; frame_tick = 1'b0; load_start = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_glyph = '0; mlen = 0;
    repeat (3) cyc();
    push_spaces(); check_window("rst");
    chk("rst.rdy", load_ready, 1'b0);
    chk("rst.scr", scrolling, 1'b0);
    rst_n = 1'b1;
    cyc();

    pulse_start();
    chk("pp.rdy_load", load_ready, 1'b1);
    push_spaces(); check_window("pp.load");
    send_title("pink panther");
    chk("pp.scr", scrolling, 1'b0);
    chk("pp.rdy_done", load_ready, 1'b0);
    push_window(0); check_window("pp");
    chk("pp.char1", chv[0], 9'h080);
    chk("pp.char5", chv[4], 9'h100);
    chk("pp.char9", chv[8], 9'h0A0);
    chk("pp.char12", chv[11], 9'h090);
    repeat (100) tick();
    push_window(0); check_window("pp.100");
    chk("pp.scr100", scrolling, 1'b0);

    pulse_start();
    send_title("pink");
    push_window(0); check_window("pink");
    chk("pink.char2", chv[1], 9'h048);
    chk("pink.char4", chv[3], 9'h058);

    pulse_start();
    send_title("the pink panther");
    chk("tpp.scr", scrolling, 1'b1);
    push_window(0); check_window("tpp.t0");
    for (int k = 0; k < 16; k++) begin
      tick();
      push_window(scroll_off[k % 8]);
      check_window($sformatf("tpp.t%0d", k + 1));
      chk($sformatf("tpp.scr%0d", k + 1), scrolling, 1'b1);
      if (k == 2) chk("tpp.h_at_t3", chv[0], 9'h040);
      if (k == 5) chk("tpp.p_at_t6", chv[0], 9'h080);
      if (k == 7) chk("tpp.t_at_t8", chv[0], 9'h0A0);
    end

    repeat (3) tick();
    load_start = 1'b1; frame_tick = 1'b1; cyc();
    load_start = 1'b0; frame_tick = 1'b0; mlen = 0;
    push_spaces(); check_window("ls_tick");
    chk("ls_tick.scr", scrolling, 1'b0);
    chk("ls_tick.rdy", load_ready, 1'b1);
    cyc();
    push_spaces(); check_window("ls_tick.hold");

    send_title("abcdefghijklm");
    for (int k = 0; k < 5; k++) begin
      tick();
      push_window(short_off[k]);
      check_window($sformatf("m13.t%0d", k + 1));
    end

    pulse_start();
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("l40.rdy%0d", k), load_ready, 1'b1);
      send_glyph(6'((k % 26) + 1), k == 39);
    end
    chk("l40.rdy_done", load_ready, 1'b0);
    chk("l40.scr", scrolling, 1'b1);
    push_window(0); check_window("l40.off0");
    repeat (2) tick();
    push_window(0); check_window("l40.hold");
    repeat (20) tick();
    push_window(20); check_window("l40.off20");
    chk("l40.last_slot", chv[11], {6'd6, 3'b000});

    async_reset("arst_scroll");

    pulse_start();
    send_glyph(6'd3, 1'b0);
    send_glyph(6'd4, 1'b0);
    send_glyph(6'd5, 1'b0);
    async_reset("arst_load");
    pulse_start();
    chk("arst.rdy_restart", load_ready, 1'b1);
    send_title("ab");
    push_window(0); check_window("arst.ab");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
